// File: rtl/tpu_host_pkg.sv
// Shared types and helpers for the TPU host controller: FSM states,
// default widths and the word-count arithmetic used at config accept.
package tpu_host_pkg;

    localparam int ADDR_BITS_DEF  = 16;
    localparam int DATA_BITS_DEF  = 32;
    localparam int DATAC_BITS_DEF = 128;

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_B, START, WAIT_HI, WAIT_LO, DRAIN
    } state_e;

    // Number of 4-lane groups needed to cover x elements (6-bit result).
    function automatic logic [5:0] ceil4(input logic [7:0] x);
        logic [8:0] s;
        s = {1'b0, x} + 9'd3;
        return s[7:2];
    endfunction

    // rows * ceil4(cols), 14-bit product.
    function automatic logic [13:0] word_count(input logic [7:0] rows, input logic [7:0] cols);
        return 14'(rows) * 14'(ceil4(cols));
    endfunction

endpackage

// File: rtl/tpu_host_ctrl_c_skid_buffer.sv
// Two-entry FIFO between the C read port and the host result stream.
// credit_o is occupancy after this cycle's pop, so reads can stream at full rate.
module c_skid_buffer #(
    parameter int W = 129
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic [1:0]   credit_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         push, pop;

    assign in_ready_o  = (cnt_q != 2'd2);
    assign out_valid_o = (cnt_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign credit_o    = cnt_q - {1'b0, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/tpu_host_ctrl.sv
// Host-side initiator for the TPU global buffers: loads A/B from the operand
// stream, kicks the TPU, waits for completion, then streams C back out.
module tpu_host_ctrl
    import tpu_host_pkg::*;
#(
    parameter int ADDR_BITS  = ADDR_BITS_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int DATAC_BITS = DATAC_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [7:0]            cfg_K,
    input  logic [7:0]            cfg_M,
    input  logic [7:0]            cfg_N,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_BITS-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATAC_BITS-1:0] out_data,
    output logic                  out_last,
    output logic                  done,
    output logic                  err,
    output logic                  tpu_in_valid,
    output logic [7:0]            tpu_K,
    output logic [7:0]            tpu_M,
    output logic [7:0]            tpu_N,
    input  logic                  tpu_busy,
    output logic                  A_wr_en,
    output logic [ADDR_BITS-1:0]  A_index,
    output logic [DATA_BITS-1:0]  A_data_in,
    output logic                  B_wr_en,
    output logic [ADDR_BITS-1:0]  B_index,
    output logic [DATA_BITS-1:0]  B_data_in,
    output logic [ADDR_BITS-1:0]  C_index,
    input  logic [DATAC_BITS-1:0] C_data_out
);
    state_e                 state_q;
    logic [7:0]             k_q, m_q, n_q;
    logic [ADDR_BITS-1:0]   a_words_q, b_words_q, c_words_q;
    logic [ADDR_BITS-1:0]   idx_q, rd_cnt_q, c_index_q;
    logic [ADDR_BITS-1:0]   a_index_q, b_index_q;
    logic [DATA_BITS-1:0]   a_data_q, b_data_q;
    logic                   a_wr_q, b_wr_q, err_q, done_q, start_q;
    logic                   rd_inflight_q, rd_last_q;
    logic                   rd_issue, sb_in_ready, out_fire;
    logic [1:0]             sb_credit, credit_sum;
    logic [DATAC_BITS:0]    sb_out;

    assign cfg_ready    = (state_q == IDLE);
    assign in_ready     = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign tpu_K        = k_q;
    assign tpu_M        = m_q;
    assign tpu_N        = n_q;
    assign A_wr_en      = a_wr_q;
    assign A_index      = a_index_q;
    assign A_data_in    = a_data_q;
    assign B_wr_en      = b_wr_q;
    assign B_index      = b_index_q;
    assign B_data_in    = b_data_q;
    assign C_index      = c_index_q;
    assign err          = err_q;
    assign done         = done_q;
    assign tpu_in_valid = start_q;
    assign out_data     = sb_out[DATAC_BITS-1:0];
    assign out_last     = sb_out[DATAC_BITS];
    assign out_fire     = out_valid && out_ready;

    // A read may only issue if the buffer is guaranteed room when its data lands.
    assign credit_sum = sb_credit + {1'b0, rd_inflight_q};
    assign rd_issue   = (state_q == DRAIN) && (rd_cnt_q < c_words_q)
                        && (credit_sum < 2'd2) && sb_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            m_q           <= '0;
            n_q           <= '0;
            a_words_q     <= '0;
            b_words_q     <= '0;
            c_words_q     <= '0;
            idx_q         <= '0;
            rd_cnt_q      <= '0;
            c_index_q     <= '0;
            a_index_q     <= '0;
            b_index_q     <= '0;
            a_data_q      <= '0;
            b_data_q      <= '0;
            a_wr_q        <= 1'b0;
            b_wr_q        <= 1'b0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            start_q       <= 1'b0;
            rd_inflight_q <= 1'b0;
            rd_last_q     <= 1'b0;
        end else begin
            a_wr_q        <= 1'b0;
            b_wr_q        <= 1'b0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            start_q       <= 1'b0;
            rd_inflight_q <= rd_issue;
            rd_last_q     <= rd_issue && (rd_cnt_q == c_words_q - ADDR_BITS'(1));
            if (rd_issue) begin
                c_index_q <= c_index_q + ADDR_BITS'(1);
                rd_cnt_q  <= rd_cnt_q + ADDR_BITS'(1);
            end
            case (state_q)
                IDLE: if (cfg_valid) begin
                    k_q       <= cfg_K;
                    m_q       <= cfg_M;
                    n_q       <= cfg_N;
                    idx_q     <= '0;
                    rd_cnt_q  <= '0;
                    c_index_q <= '0;
                    if (cfg_K == 8'd0 || cfg_M == 8'd0 || cfg_N == 8'd0) begin
                        err_q <= 1'b1;
                    end else begin
                        a_words_q <= ADDR_BITS'(word_count(cfg_K, cfg_M));
                        b_words_q <= ADDR_BITS'(word_count(cfg_K, cfg_N));
                        c_words_q <= ADDR_BITS'(word_count(cfg_M, cfg_N));
                        state_q   <= LOAD_A;
                    end
                end
                LOAD_A: if (in_valid) begin
                    a_wr_q    <= 1'b1;
                    a_index_q <= idx_q;
                    a_data_q  <= in_data;
                    if (idx_q == a_words_q - ADDR_BITS'(1)) begin
                        idx_q   <= '0;
                        state_q <= LOAD_B;
                    end else begin
                        idx_q <= idx_q + ADDR_BITS'(1);
                    end
                end
                LOAD_B: if (in_valid) begin
                    b_wr_q    <= 1'b1;
                    b_index_q <= idx_q;
                    b_data_q  <= in_data;
                    if (idx_q == b_words_q - ADDR_BITS'(1)) begin
                        idx_q   <= '0;
                        start_q <= 1'b1;
                        state_q <= START;
                    end else begin
                        idx_q <= idx_q + ADDR_BITS'(1);
                    end
                end
                START:   state_q <= WAIT_HI;
                WAIT_HI: if (tpu_busy)  state_q <= WAIT_LO;
                WAIT_LO: if (!tpu_busy) state_q <= DRAIN;
                DRAIN: if (out_fire && out_last) begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    c_skid_buffer #(.W(DATAC_BITS + 1)) u_c_skid (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (rd_inflight_q),
        .in_ready_o  (sb_in_ready),
        .in_data_i   ({rd_last_q, C_data_out}),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (sb_out),
        .credit_o    (sb_credit)
    );

endmodule

// File: doc/tpu_host_ctrl.md
# tpu_host_ctrl

Host-side controller for the TPU core, acting as the initiator for the TPU's global-buffer interface. It accepts a matrix-multiply configuration and a stream of operand words from the host, and writes them into global buffers A and B. It then pulses the TPU start, waits for the TPU to finish, and streams global buffer C back to the host. It writes A/B where the TPU reads them, and reads C where the TPU writes it.

## Interface
Parameters:
- ADDR_BITS, 16, global-buffer index width
- DATA_BITS, 32, A/B word width (4 packed int8)
- DATAC_BITS, 128, C word width (4 packed int32)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; asynchronous, active-high
- cfg_valid / cfg_ready  in / out  1 / 1  config handshake
- cfg_K, cfg_M, cfg_N  in  8 each  matrix dimensions
- in_valid / in_ready  in / out  1 / 1  operand stream handshake
- in_data  in  DATA_BITS  operand word: all A words, then all B words
- out_valid / out_ready  out / in  1 / 1  result stream handshake
- out_data  out  DATAC_BITS  C word
- out_last  out  1  high with the final C word
- done  out  1  one-cycle pulse at job end
- err  out  1  one-cycle pulse on rejected config
- tpu_in_valid  out  1  one-cycle TPU start
- tpu_K, tpu_M, tpu_N  out  8 each  latched dimensions to the TPU
- tpu_busy  in  1  TPU busy
- A_wr_en, A_index, A_data_in  out  1 / ADDR_BITS / DATA_BITS  buffer A write port
- B_wr_en, B_index, B_data_in  out  1 / ADDR_BITS / DATA_BITS  buffer B write port
- C_index  out  ADDR_BITS  buffer C read address
- C_data_out  in  DATAC_BITS  buffer C read data; 1-cycle latency

## Operation
- Derived counts are latched at config accept:
  - a_words = K*ceil(M/4)
  - b_words = K*ceil(N/4)
  - c_words = M*ceil(N/4)
  - ceil(x/4) = (x+3)>>2, 6 bits; each product 14 bits, zero-extended to ADDR_BITS.
- FSM states: IDLE, LOAD_A, LOAD_B, START, WAIT_HI, WAIT_LO, DRAIN.
- IDLE: cfg_ready=1. On accept, latch K/M/N into tpu_K/M/N.
  - If any dimension is 0: err pulse next cycle, stay IDLE.
  - Otherwise go to LOAD_A.
- LOAD_A: in_ready=1. Each accepted word is written to A at index 0..a_words-1. After the last word, go to LOAD_B.
- LOAD_B: same behaviour into B, index 0..b_words-1, then go to START.
- START: tpu_in_valid=1 for exactly one cycle, then WAIT_HI.
- WAIT_HI: wait for tpu_busy=1, then WAIT_LO.
- WAIT_LO: wait for tpu_busy=0, then DRAIN.
- DRAIN: issue C reads at index 0..c_words-1 into a 2-entry output buffer.
  - A read issues only when (occupancy + reads in flight) < 2.
  - out_last is asserted with word c_words-1.
  - After the last handshake: done pulse, return to IDLE.
- tpu_K/M/N stay stable from accept until done.
- Outside their states, in_ready and cfg_ready are 0; input words arriving then are not consumed.

## Timing
- A/B write ports are registered: an accept at cycle t drives wr_en/index/data at t+1 for one cycle. wr_en is 0 otherwise.
- Gaps in in_valid stall the index; indices stay contiguous.
- C read at cycle t: data captured at t+1. With out_ready held high, first out_valid is 2 cycles after entering DRAIN, then 1 word/cycle.
- Output holds out_data/out_last stable while out_valid=1 and out_ready=0; no drop, no duplication.
- tpu_busy already high in the START cycle: WAIT_HI exits on the first cycle busy is sampled high.
- Reset (async, any state) sets: state IDLE, buffer flushed, counters 0.
- Output values after reset deassertion:
  - cfg_ready=1
  - all other outputs 0, including tpu_K/M/N, indices and data.
- A reset mid-job abandons the job; the next config starts from index 0.

## Structure
- Shared package tpu_host_pkg:
  - FSM state enum
  - ADDR_BITS/DATA_BITS/DATAC_BITS defaults
  - ceil4 function
  - word-count function
- Sub-module c_skid_buffer: 2-entry, DATAC_BITS+1 wide (data + last), valid/ready on both sides, with an occupancy output used for read credit.

## Test plan
- M=N=K=4: 4 A words + 4 B words -> A/B indices 0..3 written; one tpu_in_valid; stub busy 10 cycles; 4 C words out, out_last on the 4th; done pulse.
- M=8, N=5, K=3 -> a_words=6, b_words=6, c_words=16; C indices 0..15 read in order; out_data matches preloaded C.
- Repeat the previous case with out_ready toggling 1,0,0,1 -> all 16 words delivered once, in order; data stable while stalled.
- cfg_K=0 -> err pulse; no A/B write, no tpu_in_valid; cfg_ready stays 1.
- rst asserted at the 3rd B word -> all outputs 0 immediately, cfg_ready=1 after release; a new M=N=K=4 job completes correctly from index 0.
- in_valid with random gaps during LOAD_A -> A_index contiguous 0..a_words-1; A_wr_en count equals a_words.
